// File: rtl/chacha_pkg.sv
// Register map and shared types for the chacha stream sequencer.
// Addresses match the chacha core's register bus.
package chacha_pkg;

    localparam logic [7:0] ADDR_CONTROL = 8'h0a;
    localparam logic [7:0] ADDR_STATUS  = 8'h0b;
    localparam logic [7:0] ADDR_KEYLEN  = 8'h0c;
    localparam logic [7:0] ADDR_ROUNDS  = 8'h0d;
    localparam logic [7:0] ADDR_KEY0    = 8'h30;
    localparam logic [7:0] ADDR_NONCE0  = 8'h38;
    localparam logic [7:0] ADDR_INPUT0  = 8'h50;
    localparam logic [7:0] ADDR_OUTPUT0 = 8'h70;

    localparam logic [31:0] CTRL_INIT = 32'h1;
    localparam logic [31:0] CTRL_NEXT = 32'h2;

    localparam int unsigned STATUS_READY_BIT = 0;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StLoad,
        StCtrl,
        StPoll,
        StRead,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// Chacha register bus: one access per cycle, read_data is combinational from addr.
// The sequencer is the master; the chacha core (or a model of it) is the slave.
interface chacha_stream_ctrl_if;

    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output cs,
        output we,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  write_data,
        output read_data
    );

endinterface

// File: rtl/chacha_stream_ctrl.sv
// Sequencer that drives the chacha register bus from a word stream: configures the core,
// loads 16-word blocks (zero padded after s_last), kicks init/next, polls ready, streams output.
module chacha_stream_ctrl
    import chacha_pkg::*;
#(
    parameter int unsigned POLL_TIMEOUT = 4096,
    parameter int unsigned KEYLEN_VAL   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [255:0]           key,
    input  logic [95:0]            nonce,
    input  logic [4:0]             rounds,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_data,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    chacha_stream_ctrl_if.master   bus
);

    localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);

    ctrl_state_e      state_q;
    logic [7:0][31:0] key_q;
    logic [2:0][31:0] nonce_q;
    logic [4:0]       rounds_q;
    logic [3:0]       cfg_idx_q;
    logic [3:0]       w_q;
    logic [3:0]       r_q;
    logic [3:0]       last_idx_q;
    logic             pad_q;
    logic             first_q;
    logic             ctrl_ph_q;
    logic [PollW-1:0] poll_q;
    logic             cs_q;
    logic             we_q;
    logic [7:0]       addr_q;
    logic [31:0]      wdata_q;

    logic [7:0]       cfg_addr;
    logic [31:0]      cfg_data;
    logic             rd_final;

    assign bus.cs         = cs_q;
    assign bus.we         = we_q;
    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;

    // Config write table: key words, nonce words, rounds, keylen.
    always_comb begin
        cfg_addr = ADDR_KEY0 + {5'd0, cfg_idx_q[2:0]};
        cfg_data = key_q[3'd7 - cfg_idx_q[2:0]];
        if (cfg_idx_q == 4'd11) begin
            cfg_addr = ADDR_ROUNDS;
            cfg_data = {27'd0, rounds_q};
        end else if (cfg_idx_q == 4'd12) begin
            cfg_addr = ADDR_KEYLEN;
            cfg_data = 32'(KEYLEN_VAL);
        end else if (cfg_idx_q >= 4'd8) begin
            cfg_addr = ADDR_NONCE0 + {6'd0, cfg_idx_q[1:0]};
            cfg_data = nonce_q[2'd2 - cfg_idx_q[1:0]];
        end
    end

    // A short final block only returns the words that were actually supplied.
    assign rd_final = (r_q == (pad_q ? last_idx_q : 4'd15));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            key_q      <= '0;
            nonce_q    <= '0;
            rounds_q   <= '0;
            cfg_idx_q  <= '0;
            w_q        <= '0;
            r_q        <= '0;
            last_idx_q <= '0;
            pad_q      <= 1'b0;
            first_q    <= 1'b1;
            ctrl_ph_q  <= 1'b0;
            poll_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            cs_q <= 1'b0;
            we_q <= 1'b0;
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q     <= key;
                        nonce_q   <= nonce;
                        rounds_q  <= rounds;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        first_q   <= 1'b1;
                        cfg_idx_q <= '0;
                        state_q   <= StCfg;
                    end
                end
                StCfg: begin
                    cs_q    <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= cfg_addr;
                    wdata_q <= cfg_data;
                    if (cfg_idx_q == 4'd12) begin
                        w_q     <= '0;
                        pad_q   <= 1'b0;
                        s_ready <= 1'b1;
                        state_q <= StLoad;
                    end else begin
                        cfg_idx_q <= cfg_idx_q + 4'd1;
                    end
                end
                StLoad: begin
                    if (pad_q || (s_valid && s_ready)) begin
                        cs_q    <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_INPUT0 + {4'd0, w_q};
                        wdata_q <= pad_q ? 32'd0 : s_data;
                        if (!pad_q && s_last) begin
                            pad_q      <= 1'b1;
                            last_idx_q <= w_q;
                            s_ready    <= 1'b0;
                        end
                        if (w_q == 4'd15) begin
                            s_ready   <= 1'b0;
                            ctrl_ph_q <= 1'b0;
                            state_q   <= StCtrl;
                        end else begin
                            w_q <= w_q + 4'd1;
                        end
                    end
                end
                StCtrl: begin
                    cs_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_CONTROL;
                    if (!ctrl_ph_q) begin
                        wdata_q   <= first_q ? CTRL_INIT : CTRL_NEXT;
                        ctrl_ph_q <= 1'b1;
                    end else begin
                        wdata_q <= 32'd0;
                        first_q <= 1'b0;
                        poll_q  <= '0;
                        state_q <= StPoll;
                    end
                end
                StPoll: begin
                    cs_q   <= 1'b1;
                    addr_q <= ADDR_STATUS;
                    // Only a read access in flight carries a valid status word.
                    if (cs_q && !we_q) begin
                        if (bus.read_data[STATUS_READY_BIT]) begin
                            cs_q    <= 1'b0;
                            r_q     <= '0;
                            state_q <= StRead;
                        end else if (poll_q == PollLast) begin
                            cs_q    <= 1'b0;
                            err     <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            poll_q <= poll_q + 1'b1;
                        end
                    end
                end
                StRead: begin
                    if (m_valid) begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            if (rd_final) begin
                                if (pad_q) begin
                                    state_q <= StDone;
                                end else begin
                                    w_q     <= '0;
                                    s_ready <= 1'b1;
                                    state_q <= StLoad;
                                end
                            end else begin
                                r_q    <= r_q + 4'd1;
                                cs_q   <= 1'b1;
                                addr_q <= ADDR_OUTPUT0 + {4'd0, r_q + 4'd1};
                            end
                        end
                    end else if (cs_q) begin
                        m_data  <= bus.read_data;
                        m_valid <= 1'b1;
                        m_last  <= pad_q && rd_final;
                    end else begin
                        cs_q   <= 1'b1;
                        addr_q <= ADDR_OUTPUT0 + {4'd0, r_q};
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
